// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared widths, funct3 load/store codes and request type for the data path
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ALEN = 32;

    localparam logic [2:0] F3_BYTE = 3'b000;
    localparam logic [2:0] F3_HALF = 3'b001;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_LBU  = 3'b100;
    localparam logic [2:0] F3_LHU  = 3'b101;

    typedef struct packed {
        logic            we;
        logic [2:0]      funct3;
        logic [ALEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } dmem_req_t;

    // funct3[2] only selects signedness, so access size comes from funct3[1:0]
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane enables and store replication; load lane extraction and extension
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]      st_funct3_i,
    input  logic [1:0]      st_addr_lo_i,
    input  logic [XLEN-1:0] st_wdata_i,
    output logic [3:0]      st_be_o,
    output logic [XLEN-1:0] st_wdata_o,
    input  logic [2:0]      ld_funct3_i,
    input  logic [1:0]      ld_addr_lo_i,
    input  logic [XLEN-1:0] ld_word_i,
    output logic [XLEN-1:0] ld_rdata_o
);

    logic [XLEN-1:0] ld_shifted;
    logic            ld_signed;

    assign ld_shifted = ld_word_i >> {ld_addr_lo_i, 3'b000};
    assign ld_signed  = !ld_funct3_i[2];

    always_comb begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_wdata_i;
        case (st_funct3_i[1:0])
            2'b00: begin
                st_be_o    = 4'b0001 << st_addr_lo_i;
                st_wdata_o = {4{st_wdata_i[7:0]}};
            end
            2'b01: begin
                st_be_o    = 4'b0011 << st_addr_lo_i;
                st_wdata_o = {2{st_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_rdata_o = ld_word_i;
        case (ld_funct3_i[1:0])
            2'b00:   ld_rdata_o = {{24{ld_signed & ld_shifted[7]}}, ld_shifted[7:0]};
            2'b01:   ld_rdata_o = {{16{ld_signed & ld_shifted[15]}}, ld_shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - handshaked data-memory controller with byte-lane RAM and LED MMIO register
module dmem_ctrl
    import riscv_pkg::*;
#(
    parameter int              DEPTH_WORDS = 1024,
    parameter logic [ALEN-1:0] LED_ADDR    = 32'hFFFF_0000,
    parameter int              LED_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [ALEN-1:0]  req_addr,
    input  logic [XLEN-1:0]  req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_rdata,
    output logic             rsp_fault,
    output logic [LED_W-1:0] leds_out
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [XLEN-1:0]  mem_q [DEPTH_WORDS];
    logic [XLEN-1:0]  rd_word_q;
    logic             rsp_valid_q, rsp_valid_d;
    logic             fault_q, led_sel_q;
    logic [2:0]       funct3_q;
    logic [1:0]       addr_lo_q;
    logic [LED_W-1:0] leds_q;

    dmem_req_t        req;
    logic             accept, is_led, in_ram, acc_fault, ram_we, led_we;
    logic [IDX_W-1:0] ram_idx;
    logic [3:0]       be;
    logic [XLEN-1:0]  wdata_rep, ld_word, ld_rdata;

    assign req       = {req_we, req_funct3, req_addr, req_wdata};
    assign req_ready = !rsp_valid_q || rsp_ready;
    assign accept    = req_valid && req_ready;

    assign is_led    = req.addr[ALEN-1:2] == LED_ADDR[ALEN-1:2];
    assign in_ram    = req.addr[ALEN-1:IDX_W+2] == '0;
    assign acc_fault = is_misaligned(req.funct3, req.addr[1:0]) || (!is_led && !in_ram);
    assign ram_idx   = req.addr[IDX_W+1:2];

    // rst gates both write strobes so a store accepted alongside reset is lost
    assign ram_we = accept && req.we && !acc_fault && !is_led && !rst;
    assign led_we = accept && req.we && !acc_fault && is_led && be[0] && !rst;

    lsu_align u_align (
        .st_funct3_i  (req.funct3),
        .st_addr_lo_i (req.addr[1:0]),
        .st_wdata_i   (req.wdata),
        .st_be_o      (be),
        .st_wdata_o   (wdata_rep),
        .ld_funct3_i  (funct3_q),
        .ld_addr_lo_i (addr_lo_q),
        .ld_word_i    (ld_word),
        .ld_rdata_o   (ld_rdata)
    );

    // No reset here so the array and its output register map onto block RAM
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[ram_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
        if (accept) rd_word_q <= mem_q[ram_idx];
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        if (accept)         rsp_valid_d = !req.we || acc_fault;
        else if (rsp_ready) rsp_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            fault_q     <= 1'b0;
            led_sel_q   <= 1'b0;
            funct3_q    <= 3'b000;
            addr_lo_q   <= 2'b00;
            leds_q      <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            if (accept) begin
                fault_q   <= acc_fault;
                led_sel_q <= is_led;
                funct3_q  <= req.funct3;
                addr_lo_q <= req.addr[1:0];
            end
            if (led_we) leds_q <= req.wdata[LED_W-1:0];
        end
    end

    always_comb begin
        ld_word = rd_word_q;
        if (led_sel_q) begin
            ld_word               = '0;
            ld_word[LED_W-1:0]    = leds_q;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_fault = rsp_valid_q && fault_q;
    assign rsp_rdata = (rsp_valid_q && !fault_q) ? ld_rdata : '0;
    assign leds_out  = leds_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed and randomized bench for dmem_ctrl against a byte-array reference model
module tb_dmem_ctrl;
    import riscv_pkg::*;

    localparam int          DEPTH = 128;
    localparam logic [31:0] LED_A = 32'hFFFF_0000;

    logic        clk, rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_fault;
    logic [31:0] rsp_rdata;
    logic [3:0]  leds_out;

    dmem_ctrl #(.DEPTH_WORDS(DEPTH), .LED_ADDR(LED_A), .LED_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault),
        .leds_out   (leds_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        f;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mem_m [DEPTH*4];
    logic [3:0]  leds_m;
    exp_t        exp_q [$];
    bit          sb_en = 0;
    bit          rand_ready = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_word(input int a);
        return {mem_m[a+3], mem_m[a+2], mem_m[a+1], mem_m[a]};
    endfunction

    // Access of n bytes at a: legal only if a is a multiple of n and hits RAM or the LED word
    function automatic void model_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] wd, output logic has_rsp,
                                     output logic [31:0] d, output logic f);
        int          n;
        int          off;
        logic        led, inram;
        logic [31:0] v, lw;
        n     = acc_size(f3);
        off   = int'(a[1:0]);
        led   = (a >> 2) == (LED_A >> 2);
        inram = !led && ((a >> 2) < DEPTH);
        has_rsp = 1'b1;
        d = 32'h0;
        f = 1'b1;
        if ((off % n) != 0 || !(led || inram)) return;
        f = 1'b0;
        if (we) begin
            has_rsp = 1'b0;
            if (led) begin
                if (off == 0) leds_m = wd[3:0];
            end else begin
                for (int k = 0; k < n; k++) mem_m[int'(a)+k] = wd[8*k +: 8];
            end
            return;
        end
        v = 32'h0;
        for (int k = 0; k < n; k++) begin
            if (led) begin
                lw = {28'h0, leds_m} >> (8 * (off + k));
                v[8*k +: 8] = lw[7:0];
            end else begin
                v[8*k +: 8] = mem_m[int'(a)+k];
            end
        end
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        d = v;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int          n;
        logic        h, f;
        logic [31:0] d;
        n = 0;
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        #1;
        while (!req_ready && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        model_op(we, f3, a, wd, h, d, f);
        if (h && sb_en) exp_q.push_back('{d, f});
        @(negedge clk);
    endtask

    task automatic op_expect(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic exp_v, input logic [31:0] exp_d, input logic exp_f);
        issue(we, f3, a, wd);
        req_valid = 1'b0;
        check({tag, "_valid"}, {31'h0, rsp_valid}, {31'h0, exp_v});
        if (exp_v) begin
            check({tag, "_rdata"}, rsp_rdata, exp_d);
            check({tag, "_fault"}, {31'h0, rsp_fault}, {31'h0, exp_f});
        end
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : scoreboard
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_en && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_spurious", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_rdata", rsp_rdata, e.d);
                    check("rsp_fault", {31'h0, rsp_fault}, {31'h0, e.f});
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    logic [2:0]  f3s [5];
    logic [31:0] exp104;

    initial begin : main
        logic [31:0] a;
        logic [2:0]  f3;
        f3s = '{F3_BYTE, F3_HALF, F3_WORD, F3_LBU, F3_LHU};
        rst = 1'b1; rsp_ready = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = F3_WORD; req_addr = 32'h0; req_wdata = 32'h0;
        leds_m = 4'h0;
        repeat (3) @(negedge clk);
        check("reset_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        check("reset_rsp_fault", {31'h0, rsp_fault}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_leds", {28'h0, leds_out}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {31'h0, req_ready}, 32'd1);

        for (int w = 0; w < DEPTH; w++) issue(1'b1, F3_WORD, 32'(w * 4), $urandom);
        req_valid = 1'b0;

        op_expect("sw_100", 1'b1, F3_WORD, 32'h100, 32'h12345678, 1'b0, 32'h0, 1'b0);
        op_expect("lw_100", 1'b0, F3_WORD, 32'h100, 32'h0, 1'b1, 32'h12345678, 1'b0);
        op_expect("sb_101", 1'b1, F3_BYTE, 32'h101, 32'h000000AA, 1'b0, 32'h0, 1'b0);
        op_expect("lw_100b", 1'b0, F3_WORD, 32'h100, 32'h0, 1'b1, 32'h1234AA78, 1'b0);
        op_expect("lb_101", 1'b0, F3_BYTE, 32'h101, 32'h0, 1'b1, 32'hFFFFFFAA, 1'b0);
        op_expect("lbu_101", 1'b0, F3_LBU, 32'h101, 32'h0, 1'b1, 32'h000000AA, 1'b0);
        op_expect("sh_102", 1'b1, F3_HALF, 32'h102, 32'h00008001, 1'b0, 32'h0, 1'b0);
        op_expect("lh_102", 1'b0, F3_HALF, 32'h102, 32'h0, 1'b1, 32'hFFFF8001, 1'b0);
        op_expect("lhu_102", 1'b0, F3_LHU, 32'h102, 32'h0, 1'b1, 32'h00008001, 1'b0);
        op_expect("lw_102_mis", 1'b0, F3_WORD, 32'h102, 32'h0, 1'b1, 32'h0, 1'b1);
        op_expect("sw_102_mis", 1'b1, F3_WORD, 32'h102, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b1);
        op_expect("lw_100c", 1'b0, F3_WORD, 32'h100, 32'h0, 1'b1, 32'h8001AA78, 1'b0);

        op_expect("sw_led", 1'b1, F3_WORD, LED_A, 32'h5, 1'b0, 32'h0, 1'b0);
        check("leds_after_sw", {28'h0, leds_out}, 32'h5);
        op_expect("lw_led", 1'b0, F3_WORD, LED_A, 32'h0, 1'b1, 32'h5, 1'b0);
        op_expect("sw_oor", 1'b1, F3_WORD, 32'(DEPTH * 4), 32'h0BADF00D, 1'b1, 32'h0, 1'b1);
        op_expect("lw_oor", 1'b0, F3_WORD, 32'(DEPTH * 4 + 4), 32'h0, 1'b1, 32'h0, 1'b1);
        check("leds_after_oor", {28'h0, leds_out}, 32'h5);
        op_expect("lw_0_after_oor", 1'b0, F3_WORD, 32'h0, 32'h0, 1'b1, model_word(0), 1'b0);

        // Back-to-back loads with the consumer stalled for three cycles
        exp104 = model_word(32'h104);
        issue(1'b0, F3_WORD, 32'h100, 32'h0);
        rsp_ready = 1'b0;
        req_addr = 32'h104;
        #1;
        for (int c = 0; c < 3; c++) begin
            check("stall_req_ready", {31'h0, req_ready}, 32'd0);
            check("stall_rsp_valid", {31'h0, rsp_valid}, 32'd1);
            check("stall_rdata_held", rsp_rdata, 32'h8001AA78);
            @(negedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("stall_second_valid", {31'h0, rsp_valid}, 32'd1);
        check("stall_second_rdata", rsp_rdata, exp104);
        req_valid = 1'b0;
        @(negedge clk);
        check("stall_drained", {31'h0, rsp_valid}, 32'd0);

        // Reset while a response is pending, with a store presented in the reset cycle
        issue(1'b0, F3_WORD, 32'h100, 32'h0);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rsp_ready = 1'b1;
        req_we = 1'b1; req_funct3 = F3_WORD; req_addr = 32'h104; req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
        @(negedge clk);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        check("rst_leds", {28'h0, leds_out}, 32'd0);
        leds_m = 4'h0;
        req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'h0, req_ready}, 32'd1);
        op_expect("lw_100_kept", 1'b0, F3_WORD, 32'h100, 32'h0, 1'b1, 32'h8001AA78, 1'b0);
        op_expect("lw_104_nostore", 1'b0, F3_WORD, 32'h104, 32'h0, 1'b1, exp104, 1'b0);

        sb_en = 1'b1;
        rand_ready = 1'b1;
        repeat (600) begin
            f3 = f3s[$urandom_range(0, 4)];
            case ($urandom_range(0, 9))
                0:       a = LED_A + 32'($urandom_range(0, 3));
                1:       a = 32'((DEPTH + $urandom_range(0, 1000)) * 4 + $urandom_range(0, 3));
                2:       a = $urandom | 32'h8000_0000;
                default: a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(0, 3));
            endcase
            issue($urandom_range(0, 1) == 1, f3, a, $urandom);
        end
        req_valid = 1'b0;
        rand_ready = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("rand_leds", {28'h0, leds_out}, {28'h0, leds_m});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised data-memory controller replacing the fixed-size, externally byte-enabled data memory on the CPU load/store path. It accepts one load/store request per cycle over a valid/ready handshake and derives byte lanes internally from funct3 and the address. Loads are sign/zero-extended and returned with backpressure support. Misaligned and out-of-range accesses are flagged, and a parametrised LED MMIO register is mapped into the address space.

## Interface
- DEPTH_WORDS, 1024, number of 32-bit RAM words; power of two, 16 to 65536.
- LED_ADDR, 32'hFFFF_0000, word-aligned MMIO address of the LED register.
- LED_W, 4, LED register width, 1 to 32.
- clk  in  1  single clock; all state is updated on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  riscv_pkg F3_* encoding: byte, half, word, LBU, LHU.
- req_addr  in  ALEN  byte address.
- req_wdata  in  XLEN  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  XLEN  extended load data; 0 for faulted operations.
- rsp_fault  out  1  access was misaligned or out of range.
- leds_out  out  LED_W  LED register contents.

## Operation
- A request is accepted when req_valid && req_ready.
- Byte enables are generated internally:
  - Byte: 1 << addr[1:0].
  - Half: 4'b0011 << addr[1:0].
  - Word: 4'b1111.
  - Write data is replicated onto the selected lanes.
- Misaligned access: a half with addr[0]=1, or a word with addr[1:0]≠0. The RAM and LED register are not modified; a response is generated with rsp_fault=1 and rsp_rdata=0.
- Address decode:
  - Word address equal to LED_ADDR[ALEN-1:2] selects the LED register.
  - Otherwise, word index addr[ALEN-1:2] < DEPTH_WORDS selects the RAM.
  - Anything else is out of range. Out-of-range stores are dropped. Out-of-range loads return 0. Both set rsp_fault=1.
- LED store: lane 0 enabled, so leds_out <= wdata[LED_W-1:0]. Other lanes are ignored.
- LED load: zero-extended leds_out, then lane-extracted like RAM data.
- Clean stores complete on accept and generate no response. Loads and all faulted operations generate exactly one response.
- Load extension: byte or half is selected by the latched addr[1:0].
  - F3_BYTE / half: sign-extended.
  - F3_LBU / LHU: zero-extended.
  - Word: passed through.
- RAM contents are not cleared by reset. The LED register is cleared by reset.

## Timing
- Reset values: rsp_valid=0, rsp_fault=0, rsp_rdata=0, leds_out=0. req_ready=1 in the cycle after reset deasserts.
- req_ready = !rsp_valid || rsp_ready. This is combinational; a same-cycle accept and drain is allowed.
- Load latency is 1. Accept at edge N gives rsp_valid=1 after N, with data valid in the same cycle.
- Sustained throughput is one access per cycle while rsp_ready=1.
- While rsp_valid && !rsp_ready:
  - rsp_rdata and rsp_fault are held stable.
  - The RAM read port is disabled; reads are enabled only on accept.
  - No request is accepted.
- Store writes at the accept edge. A load accepted on the next cycle returns the new data, so no forwarding path is needed.
- Response dropped, no new request: rsp_valid clears at the edge where rsp_ready=1 and no load or fault is accepted.
- rst mid-operation: a pending response is discarded and rsp_valid=0 after the reset edge. A store accepted in the same cycle as rst is suppressed.

## Structure
- riscv_pkg holds:
  - XLEN, ALEN and the F3_* codes; F3_HALF and F3_LHU are added if absent.
  - A new typedef dmem_req_t {we, funct3, addr, wdata}.
  - A function is_misaligned(funct3, addr[1:0]).
- One sub-module, lsu_align, which is purely combinational:
  - Store path: funct3 and addr[1:0] → be and lane-replicated wdata.
  - Load path: funct3, addr[1:0] and raw word → extended rdata.
- The top level holds:
  - The RAM array, word-addressed with per-byte write enables so it infers as block RAM.
  - The LED register.
  - The response register and handshake logic.

## Test plan
- Word store 0x12345678 at 0x100, then LW 0x100 → rsp_rdata=0x12345678, rsp_fault=0, one cycle after accept.
- SB 0xAA at 0x101, then LW 0x100 → 0x1234AA78; LB 0x101 → 0xFFFFFFAA; LBU 0x101 → 0x000000AA.
- SH 0x8001 at 0x102, then LH 0x102 → 0xFFFF8001; LHU 0x102 → 0x00008001. LW at 0x102 → rsp_fault=1, rdata=0, memory unchanged.
- SW 0x5 to LED_ADDR → leds_out=4'h5. LW LED_ADDR → 0x5. Store to word index DEPTH_WORDS → fault, leds and RAM unchanged.
- Back-to-back loads to 0x100 and 0x104 with rsp_ready=0 for 3 cycles:
  - req_ready=0 during the stall.
  - The first response is held stable.
  - After release, responses arrive in order with no loss.
- Assert rst while a load response is pending → rsp_valid=0, leds_out=0 next cycle. RAM data at 0x100 is retained.
